// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, display word type and leading-zero mask for the seven-segment scan mux
package seg_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
  typedef struct packed {
    logic [NUM_DIGITS*DIGIT_W-1:0] value;
    logic [NUM_DIGITS-1:0] dp;
  } disp_t;
  // bit i set when digits NUM_DIGITS-1..i are all zero; digit 0 is never marked
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [NUM_DIGITS*DIGIT_W-1:0] v);
    logic z;
    z = 1'b1;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      z = z & (v[i*DIGIT_W +: DIGIT_W] == '0);
      lz_mask[i] = z;
    end
  endfunction
endpackage

// File: rtl/seg_scan_mux_prescaler.sv
// seg_prescaler: free-running 0..REFRESH_DIV-1 counter with terminal-count flag
module seg_prescaler #(
  parameter int REFRESH_DIV = 100000,
  localparam int CW = $clog2(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tc_o = cnt_q == CW'(REFRESH_DIV - 1);
  assign cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  assign cnt_o = cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: double-buffered 8-digit scan controller with leading-zero blanking and dead time
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic        blank_lz,
  input  logic [7:0]  digit_en,
  output logic [3:0]  nibble,
  output logic [7:0]  an_sel,
  output logic        dp_out,
  output logic        pending,
  output logic        frame_tick
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] cnt;
  logic tc, fb, off;
  logic [2:0] idx_q, idx_d;
  disp_t shadow_q, shadow_d, disp_q, disp_d;
  logic pend_q, pend_d;
  logic [7:0] lz, an_q, an_d;
  logic [3:0] nib_q, nib_d, dig;
  logic dp_q, dp_d, ft_q;
  seg_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .cnt_o(cnt),
    .tc_o (tc)
  );
  assign fb = tc & (idx_q == 3'd7);
  // a load on the boundary edge lands in the shadow after the old shadow is applied
  always_comb begin
    idx_d = tc ? idx_q + 3'd1 : idx_q;
    shadow_d = load ? '{value: value, dp: dp_mask} : shadow_q;
    disp_d = (fb & pend_q) ? shadow_q : disp_q;
    pend_d = load | (pend_q & ~fb);
    lz = lz_mask(disp_q.value) & {NUM_DIGITS{blank_lz}};
    dig = disp_q.value[{idx_q, 2'b00} +: DIGIT_W];
    off = (int'(cnt) < BLANK_CYCLES) | ~digit_en[idx_q];
    an_d = off ? 8'h00 : 8'b1 << idx_q;
    nib_d = (off | lz[idx_q]) ? BLANK_CODE : dig;
    dp_d = ~off & disp_q.dp[idx_q];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      shadow_q <= '0;
      disp_q <= '0;
      pend_q <= 1'b0;
      an_q <= '0;
      nib_q <= BLANK_CODE;
      dp_q <= 1'b0;
      ft_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      shadow_q <= shadow_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      an_q <= an_d;
      nib_q <= nib_d;
      dp_q <= dp_d;
      ft_q <= fb;
    end
  end
  assign nibble = nib_q;
  assign an_sel = an_q;
  assign dp_out = dp_q;
  assign pending = pend_q;
  assign frame_tick = ft_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: table-driven frame checks plus load-timing and reset corner cases
module tb_seg_scan_mux;
  logic clk = 1'b0;
  logic rst, load, blank_lz, dp_out, pending, frame_tick;
  logic [31:0] value;
  logic [7:0] dp_mask, digit_en, an_sel;
  logic [3:0] nibble;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [31:0] value;
    logic [7:0]  dp;
    logic        blz;
    logic [7:0]  en;
    logic [31:0] exp_nib;
    logic [7:0]  exp_an;
    logic [7:0]  exp_dp;
  } vec_t;
  vec_t tbl[5];

  seg_scan_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .value     (value),
    .dp_mask   (dp_mask),
    .blank_lz  (blank_lz),
    .digit_en  (digit_en),
    .nibble    (nibble),
    .an_sel    (an_sel),
    .dp_out    (dp_out),
    .pending   (pending),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] dp);
    value = v;
    dp_mask = dp;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!frame_tick && k < 40);
    chk("wait_tick", 32'(frame_tick), 32'd1);
  endtask

  // starts at a point where the next edge opens the dead time of slot 0
  task automatic check_frame(input string tag, input logic [31:0] nib, input logic [7:0] an,
                             input logic [7:0] dp);
    for (int d = 0; d < 8; d++) begin
      step();
      chk($sformatf("%s d%0d dead an_sel", tag, d), 32'(an_sel), 32'd0);
      chk($sformatf("%s d%0d dead nibble", tag, d), 32'(nibble), 32'hF);
      step();
      chk($sformatf("%s d%0d an_sel", tag, d), 32'(an_sel), an[d] ? (32'd1 << d) : 32'd0);
      chk($sformatf("%s d%0d nibble", tag, d), 32'(nibble), an[d] ? 32'(nib[4*d +: 4]) : 32'hF);
      chk($sformatf("%s d%0d dp_out", tag, d), 32'(dp_out), 32'(an[d] & dp[d]));
      chk($sformatf("%s d%0d frame_tick", tag, d), 32'(frame_tick), 32'd0);
      step();
      step();
    end
    chk({tag, " end frame_tick"}, 32'(frame_tick), 32'd1);
  endtask

  initial begin
    tbl[0] = '{32'h1234_5678, 8'h01, 1'b0, 8'hFF, 32'h1234_5678, 8'hFF, 8'h01};
    tbl[1] = '{32'h0000_00A0, 8'h00, 1'b1, 8'hFF, 32'hFFFF_FFA0, 8'hFF, 8'h00};
    tbl[2] = '{32'h0000_0000, 8'h00, 1'b1, 8'hFF, 32'hFFFF_FFF0, 8'hFF, 8'h00};
    tbl[3] = '{32'h0030_0400, 8'h84, 1'b1, 8'hFF, 32'hFF30_0400, 8'hFF, 8'h84};
    tbl[4] = '{32'h8765_4321, 8'hFF, 1'b0, 8'h0F, 32'h8765_4321, 8'h0F, 8'hFF};
    rst = 1'b1;
    load = 1'b0;
    value = '0;
    dp_mask = '0;
    blank_lz = 1'b0;
    digit_en = 8'hFF;
    step();
    step();
    chk("reset an_sel", 32'(an_sel), 32'h00);
    chk("reset nibble", 32'(nibble), 32'hF);
    chk("reset dp_out", 32'(dp_out), 32'd0);
    chk("reset pending", 32'(pending), 32'd0);
    chk("reset frame_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;
    check_frame("idle", 32'h0, 8'hFF, 8'h00);
    for (int i = 0; i < 5; i++) begin
      blank_lz = tbl[i].blz;
      digit_en = tbl[i].en;
      do_load(tbl[i].value, tbl[i].dp);
      chk($sformatf("vec%0d pending set", i), 32'(pending), 32'd1);
      wait_tick();
      chk($sformatf("vec%0d pending clear", i), 32'(pending), 32'd0);
      check_frame($sformatf("vec%0d", i), tbl[i].exp_nib, tbl[i].exp_an, tbl[i].exp_dp);
    end
    blank_lz = 1'b0;
    digit_en = 8'hFF;
    step();
    do_load(32'h1, 8'h00);
    repeat (4) step();
    do_load(32'h2, 8'h00);
    chk("lastwins pending", 32'(pending), 32'd1);
    wait_tick();
    chk("lastwins pending clear", 32'(pending), 32'd0);
    check_frame("lastwins", 32'h0000_0002, 8'hFF, 8'h00);
    do_load(32'hAA, 8'h00);
    repeat (30) step();
    do_load(32'hBB, 8'h00);
    chk("coincident frame_tick", 32'(frame_tick), 32'd1);
    chk("coincident pending", 32'(pending), 32'd1);
    check_frame("coincident old", 32'h0000_00AA, 8'hFF, 8'h00);
    chk("coincident pending clear", 32'(pending), 32'd0);
    check_frame("coincident new", 32'h0000_00BB, 8'hFF, 8'h00);
    do_load(32'h99, 8'hFF);
    repeat (21) step();
    chk("midslot an_sel", 32'(an_sel), 32'h20);
    rst = 1'b1;
    #1;
    chk("midreset an_sel", 32'(an_sel), 32'h00);
    chk("midreset nibble", 32'(nibble), 32'hF);
    chk("midreset dp_out", 32'(dp_out), 32'd0);
    chk("midreset pending", 32'(pending), 32'd0);
    rst = 1'b0;
    check_frame("postreset", 32'h0, 8'hFF, 8'h00);
    chk("postreset pending", 32'(pending), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexed scan controller for the 8-digit common-anode seven-segment display.
- Sits directly upstream of the nibble-to-segment decoder. Each refresh slot it supplies one 4-bit digit code, an active-high one-hot anode select and a decimal-point bit; the decoder inverts these to the pins.
- Takes a 32-bit display word via a load strobe. The word is double-buffered, so a new value is applied only at a frame boundary (no tearing).
- Adds leading-zero blanking, per-digit enable and anti-ghosting dead time.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (100 MHz gives 1 kHz per digit, 125 Hz frame). Must be >= 2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off. Must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load  in  1  single-cycle strobe; captures value and dp_mask into the shadow register
- value  in  32  eight hex digits; digit i = value[4i+3:4i]; digit 0 is rightmost
- dp_mask  in  8  decimal point per digit, bit i = digit i
- blank_lz  in  1  1 = blank leading zeros (digit 0 is never blanked)
- digit_en  in  8  per-digit enable; a disabled digit keeps its slot with its anode off
- nibble  out  4  digit code to the decoder; 4'hF = blank
- an_sel  out  8  active-high one-hot anode select
- dp_out  out  1  active-high decimal point for the current digit
- pending  out  1  shadow holds a value not yet applied
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit 7 to digit 0

Behaviour:
- Reset (async, while rst = 1):
  - Prescaler = 0, scan index = 0, display and shadow registers = 0, pending = 0.
  - Outputs: nibble = 4'hF, an_sel = 8'h00, dp_out = 0, frame_tick = 0.
- Prescaler:
  - Counter of width $clog2(REFRESH_DIV), counts 0..REFRESH_DIV-1 and wraps.
  - At terminal count, scan index increments modulo 8 (0 -> 1 -> ... -> 7 -> 0).
- Frame boundary (terminal count with index = 7):
  - frame_tick pulses high on the next cycle.
  - If pending, the shadow is copied into the display register on the same edge and pending clears.
- Load:
  - On load = 1, shadow <= {value, dp_mask} and pending <= 1. The display register is untouched.
  - Repeated loads before a frame boundary: last one wins.
  - Load coincident with a frame boundary: the boundary copies the old shadow, the new value lands in the shadow, and pending stays 1.
- Leading-zero blanking:
  - Computed combinationally from the display register.
  - Digit i is blanked if blank_lz = 1, i > 0, and digits 7..i are all zero.
  - Value 0 shows a single "0" on digit 0.
- Output registration:
  - All outputs are registered, with 1-cycle latency from the index/prescaler state.
  - If the slot is in dead time (prescaler < BLANK_CYCLES), or digit_en[index] = 0: an_sel = 0, nibble = 4'hF, dp_out = 0.
  - Otherwise: an_sel = 1 << index; nibble = 4'hF if blanked, else the digit; dp_out = dp_mask[index] from the display register.
  - A blanked digit still asserts its anode, and dp is still shown.
- Hex F is rendered blank by the decoder (documented limitation).
- Reset mid-frame: everything returns to reset values immediately. After release, scanning restarts at digit 0 with a full dead time, and any pending load is lost.

Decomposition:
- Package seg_pkg holds: NUM_DIGITS = 8, DIGIT_W = 4, BLANK_CODE = 4'hF, and the function that computes the 8-bit leading-zero mask.
- Sub-module seg_prescaler (parameter REFRESH_DIV; outputs a count and a terminal-count pulse). All else is inline.

Test Plan (REFRESH_DIV = 4, BLANK_CYCLES = 1, digit_en = 8'hFF):
- Reset then idle -> an_sel = 00 during reset. Per slot: one cycle of 00, then three cycles of 01; then 02, 04, ... 80. frame_tick pulses once every 32 cycles.
- load value = 32'h1234_5678, dp_mask = 8'h01, blank_lz = 0 -> pending = 1 until the next frame_tick. The following frame gives nibbles 8, 7, 6, 5, 4, 3, 2, 1 on an_sel 01..80, with dp_out = 1 only on slot 01.
- load 32'h0000_00A0, blank_lz = 1 -> digit 0 = 0, digit 1 = A, digits 2..7 have nibble F with their anodes still asserted. Load 0 -> only digit 0 shows 0.
- Two loads 5 cycles apart within one frame (32'h1 then 32'h2) -> the frame shows only 2; pending clears at the boundary.
- Load asserted in the same cycle as the terminal count of digit 7 -> the old shadow is applied, pending remains 1, and the new value appears one frame later.
- digit_en = 8'h0F -> slots 10..80 show an_sel = 00, nibble F. Assert rst mid-slot at digit 5 -> outputs reset at once; after release, scanning restarts at digit 0.
